// File: rtl/sobel_gcd_spi_pkg.sv
// Shared constants and FSM encoding for the host-side SPI initiator of the sobel/gcd accelerator.
// Register addresses mirror the responder's map; pixel registers are zero-extended to the operand width.
package sobel_gcd_spi_pkg;

  localparam int CMD_WIDTH = 8;

  localparam logic [6:0] ADDR_OPERAND_A = 7'h00;
  localparam logic [6:0] ADDR_OPERAND_B = 7'h01;
  localparam logic [6:0] ADDR_GCD       = 7'h02;
  localparam logic [6:0] ADDR_PX_GRAY   = 7'h03;
  localparam logic [6:0] ADDR_PX_SOBEL  = 7'h04;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } spi_state_t;

  function automatic logic addr_is_mapped(input logic [6:0] addr);
    return addr inside {ADDR_OPERAND_A, ADDR_OPERAND_B, ADDR_GCD, ADDR_PX_GRAY, ADDR_PX_SOBEL};
  endfunction

endpackage

// File: rtl/spi_host_sck_gen.sv
// SCK half-period generator: runs only while enabled, starts on a high phase and flags the
// cycle before each edge so the host can shift SDO and sample SDI in step with the pin.
module spi_host_sck_gen
  import sobel_gcd_spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic i_start,
  input  logic i_en,
  input  logic i_last,
  output logic o_sck,
  output logic o_rise,
  output logic o_fall,
  output logic o_sample
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] PHASE_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_sck;
  logic          w_phaseEnd;

  assign w_phaseEnd = i_en && (r_cnt == PHASE_LAST);

  // On the final low phase the rise strobe still fires but the pin stays low.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_cnt <= '0;
      r_sck <= 1'b0;
    end else if (i_start) begin
      r_cnt <= '0;
      r_sck <= 1'b1;
    end else if (!i_en) begin
      r_cnt <= '0;
      r_sck <= 1'b0;
    end else if (w_phaseEnd) begin
      r_cnt <= '0;
      r_sck <= r_sck ? 1'b0 : !i_last;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_sck    = r_sck;
  assign o_rise   = w_phaseEnd && !r_sck;
  assign o_fall   = w_phaseEnd && r_sck;
  assign o_sample = w_phaseEnd && r_sck;

endmodule

// File: rtl/sobel_gcd_spi_host.sv
// SPI mode-0 initiator: serialises {write, addr, wdata} MSB first and returns the word captured
// on SDI during the data phase. Every pin is a flop loaded from the next-state decode.
module sobel_gcd_spi_host
  import sobel_gcd_spi_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CLK_DIV    = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [6:0]            req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  busy_o,
  output logic                  spi_sck_o,
  output logic                  spi_cs_o,
  output logic                  spi_sdo_o,
  input  logic                  spi_sdi_i
);

  localparam int N  = CMD_WIDTH + DATA_WIDTH;
  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(N);
  localparam logic [CW-1:0] WAIT_LAST = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(N - 1);

  generate
    if (CLK_DIV < 2) begin : g_bad_clk_div
      $error("sobel_gcd_spi_host: CLK_DIV must be at least 2");
    end
  endgenerate

  spi_state_t            r_state;
  spi_state_t            w_stateNext;
  logic [CW-1:0]         r_waitCnt;
  logic [BW-1:0]         r_bitCnt;
  logic [N-1:0]          r_shiftOut;
  logic [DATA_WIDTH-1:0] r_capture;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_sdo;
  logic                  r_cs;
  logic                  r_busy;
  logic                  r_ready;
  logic                  r_rspValid;

  logic [N-1:0]          w_frame;
  logic                  w_accept;
  logic                  w_waitDone;
  logic                  w_lastBit;
  logic                  w_sckStart;
  logic                  w_frameEnd;
  logic                  w_sck;
  logic                  w_rise;
  logic                  w_fall;
  logic                  w_sample;

  assign w_frame    = {req_write_i, req_addr_i, req_wdata_i};
  assign w_accept   = (r_state == ST_IDLE) && req_valid_i;
  assign w_waitDone = (r_waitCnt == WAIT_LAST);
  assign w_lastBit  = (r_bitCnt == BIT_LAST);
  assign w_sckStart = (r_state == ST_SETUP) && w_waitDone;
  assign w_frameEnd = (r_state == ST_HOLD) && (w_stateNext == ST_GAP);

  spi_host_sck_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sck_gen (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .i_start (w_sckStart),
    .i_en    (r_state == ST_SHIFT),
    .i_last  (w_lastBit),
    .o_sck   (w_sck),
    .o_rise  (w_rise),
    .o_fall  (w_fall),
    .o_sample(w_sample)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_state <= ST_IDLE;
    else         r_state <= w_stateNext;
  end

  // SHIFT ends on the low phase that follows the last bit, where another rise would be due.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE:  if (req_valid_i)             w_stateNext = ST_SETUP;
      ST_SETUP: if (w_waitDone)              w_stateNext = ST_SHIFT;
      ST_SHIFT: if (w_rise && w_lastBit)     w_stateNext = ST_HOLD;
      ST_HOLD:  if (w_waitDone)              w_stateNext = ST_GAP;
      ST_GAP:   if (w_waitDone)              w_stateNext = ST_IDLE;
      default:                               w_stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_waitCnt  <= '0;
      r_bitCnt   <= '0;
      r_shiftOut <= '0;
      r_capture  <= '0;
      r_rdata    <= '0;
      r_sdo      <= 1'b0;
      r_cs       <= 1'b1;
      r_busy     <= 1'b0;
      r_ready    <= 1'b1;
      r_rspValid <= 1'b0;
    end else begin
      if (w_stateNext != r_state)                        r_waitCnt <= '0;
      else if (r_state inside {ST_SETUP, ST_HOLD, ST_GAP}) r_waitCnt <= r_waitCnt + 1'b1;

      if (w_accept) begin
        r_shiftOut <= {w_frame[N-2:0], 1'b0};
        r_sdo      <= w_frame[N-1];
        r_bitCnt   <= '0;
      end else if (w_fall) begin
        r_sdo      <= r_shiftOut[N-1];
        r_shiftOut <= {r_shiftOut[N-2:0], 1'b0};
      end else if (w_stateNext == ST_GAP) begin
        r_sdo      <= 1'b0;
      end

      if (w_rise && !w_lastBit) r_bitCnt <= r_bitCnt + 1'b1;

      // Command-phase bits fall off the top; only the data word survives.
      if (w_sample) r_capture <= {r_capture[DATA_WIDTH-2:0], spi_sdi_i};

      r_cs       <= !(w_stateNext inside {ST_SETUP, ST_SHIFT, ST_HOLD});
      r_busy     <= (w_stateNext != ST_IDLE);
      r_ready    <= (w_stateNext == ST_IDLE);
      r_rspValid <= w_frameEnd;
      if (w_frameEnd) r_rdata <= r_capture;
    end
  end

  assign req_ready_o = r_ready;
  assign rsp_valid_o = r_rspValid;
  assign rsp_rdata_o = r_rdata;
  assign busy_o      = r_busy;
  assign spi_sck_o   = w_sck;
  assign spi_cs_o    = r_cs;
  assign spi_sdo_o   = r_sdo;

endmodule

// File: tb/tb_sobel_gcd_spi_host.sv
// Directed bench for sobel_gcd_spi_host: a CLK_DIV=2 and a CLK_DIV=5 instance, each facing a
// small mode-0 responder model that returns {8'h00, word} and records the frame seen on the pins.
module tb_sobel_gcd_spi_host;
  import sobel_gcd_spi_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        aValid = 0, aWrite = 0, aReady, aRspValid, aBusy, aSck, aCs, aSdo, aSdi = 0;
  logic [6:0]  aAddr = 0;
  logic [15:0] aWdata = 0, aRdata;
  logic        bValid = 0, bWrite = 0, bReady, bRspValid, bBusy, bSck, bCs, bSdo, bSdi = 0;
  logic [6:0]  bAddr = 0;
  logic [15:0] bWdata = 0, bRdata;

  sobel_gcd_spi_host #(.DATA_WIDTH(16), .CLK_DIV(2)) dutA (
    .clk_i(clk), .reset_i(reset), .req_valid_i(aValid), .req_ready_o(aReady),
    .req_write_i(aWrite), .req_addr_i(aAddr), .req_wdata_i(aWdata),
    .rsp_valid_o(aRspValid), .rsp_rdata_o(aRdata), .busy_o(aBusy),
    .spi_sck_o(aSck), .spi_cs_o(aCs), .spi_sdo_o(aSdo), .spi_sdi_i(aSdi));

  sobel_gcd_spi_host #(.DATA_WIDTH(16), .CLK_DIV(5)) dutB (
    .clk_i(clk), .reset_i(reset), .req_valid_i(bValid), .req_ready_o(bReady),
    .req_write_i(bWrite), .req_addr_i(bAddr), .req_wdata_i(bWdata),
    .rsp_valid_o(bRspValid), .rsp_rdata_o(bRdata), .busy_o(bBusy),
    .spi_sck_o(bSck), .spi_cs_o(bCs), .spi_sdo_o(bSdo), .spi_sdi_i(bSdi));

  logic        aPrevCs = 1, aPrevSck = 0;
  logic [23:0] aRespShift = 0, aSdoBits = 0;
  logic [15:0] aRespWord = 0, aRdataAtPulse = 0;
  int aCsFallCyc = 0, aCsRiseCyc = 0, aCsLowCnt = 0, aRiseCnt = 0, aFirstRiseCyc = 0;
  int aPulseCnt = 0, aPulseCyc = 0, aReadyViol = 0;

  always @(negedge clk) begin
    if (aPrevCs && !aCs) begin
      aRespShift = {8'h00, aRespWord};
      aSdi = aRespShift[23];
      aCsFallCyc = cyc; aCsLowCnt = 0; aRiseCnt = 0; aSdoBits = '0;
    end else if (!aCs && aPrevSck && !aSck) begin
      aRespShift = aRespShift << 1;
      aSdi = aRespShift[23];
    end
    if (!aPrevCs && aCs) aCsRiseCyc = cyc;
    if (!aCs) aCsLowCnt++;
    if (!aCs && aReady) aReadyViol++;
    if (!aPrevSck && aSck) begin
      if (aRiseCnt == 0) aFirstRiseCyc = cyc;
      aSdoBits = {aSdoBits[22:0], aSdo};
      aRiseCnt++;
    end
    if (aRspValid) begin aPulseCnt++; aPulseCyc = cyc; aRdataAtPulse = aRdata; end
    aPrevCs = aCs; aPrevSck = aSck;
  end

  logic        bPrevCs = 1, bPrevSck = 0;
  logic [23:0] bRespShift = 0, bSdoBits = 0;
  logic [15:0] bRespWord = 0, bRdataAtPulse = 0;
  int bCsFallCyc = 0, bCsLowCnt = 0, bRiseCnt = 0, bFallCnt = 0, bFirstRiseCyc = 0;
  int bSecondRiseCyc = 0, bFirstFallCyc = 0, bPulseCnt = 0, bPulseCyc = 0;

  always @(negedge clk) begin
    if (bPrevCs && !bCs) begin
      bRespShift = {8'h00, bRespWord};
      bSdi = bRespShift[23];
      bCsFallCyc = cyc; bCsLowCnt = 0; bRiseCnt = 0; bFallCnt = 0; bSdoBits = '0;
    end else if (!bCs && bPrevSck && !bSck) begin
      bRespShift = bRespShift << 1;
      bSdi = bRespShift[23];
    end
    if (!bCs) bCsLowCnt++;
    if (!bPrevSck && bSck) begin
      if (bRiseCnt == 0) bFirstRiseCyc = cyc;
      if (bRiseCnt == 1) bSecondRiseCyc = cyc;
      bSdoBits = {bSdoBits[22:0], bSdo};
      bRiseCnt++;
    end
    if (bPrevSck && !bSck) begin
      if (bFallCnt == 0) bFirstFallCyc = cyc;
      bFallCnt++;
    end
    if (bRspValid) begin bPulseCnt++; bPulseCyc = cyc; bRdataAtPulse = bRdata; end
    bPrevCs = bCs; bPrevSck = bSck;
  end

  task automatic waitCycles(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic issueA(input logic w, input logic [6:0] addr, input logic [15:0] d,
                        output int t, output bit ok);
    ok = 0; t = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk); #1;
      if (aReady === 1'b1) ok = 1;
    end
    if (ok) begin
      aWrite = w; aAddr = addr; aWdata = d; aValid = 1; t = cyc;
      waitCycles(1);
      aValid = 0; aWrite = ~w; aAddr = 7'h7F; aWdata = ~d;
    end
  endtask

  task automatic issueB(input logic w, input logic [6:0] addr, input logic [15:0] d,
                        output int t, output bit ok);
    ok = 0; t = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk); #1;
      if (bReady === 1'b1) ok = 1;
    end
    if (ok) begin
      bWrite = w; bAddr = addr; bWdata = d; bValid = 1; t = cyc;
      waitCycles(1);
      bValid = 0; bWrite = ~w; bAddr = 7'h7F; bWdata = ~d;
    end
  endtask

  task automatic waitPulseA(input int startCnt, output bit ok);
    ok = 0;
    for (int i = 0; i < 600 && !ok; i++) begin
      waitCycles(1);
      if (aPulseCnt > startCnt) ok = 1;
    end
  endtask

  task automatic waitPulseB(input int startCnt, output bit ok);
    ok = 0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      waitCycles(1);
      if (bPulseCnt > startCnt) ok = 1;
    end
  endtask

  task automatic test_reset();
    reset = 1;
    waitCycles(4);
    checks++;
    if ({aReady, aRspValid, aBusy, aSck, aCs, aSdo} !== 6'b100010) begin
      failures++; $display("[TB] FAIL reset_pins_a got=%b exp=100010", {aReady, aRspValid, aBusy, aSck, aCs, aSdo});
    end
    checks++;
    if (aRdata !== 16'h0000) begin failures++; $display("[TB] FAIL reset_rdata got=%h exp=0000", aRdata); end
    checks++;
    if ({bReady, bRspValid, bBusy, bSck, bCs, bSdo} !== 6'b100010) begin
      failures++; $display("[TB] FAIL reset_pins_b got=%b exp=100010", {bReady, bRspValid, bBusy, bSck, bCs, bSdo});
    end
    reset = 0;
    for (int i = 0; i < 200; i++) begin
      waitCycles(1);
      checks++;
      if ({aReady, aRspValid, aBusy, aSck, aCs, aSdo} !== 6'b100010) begin
        failures++; $display("[TB] FAIL idle_pins cyc=%0d got=%b exp=100010", cyc, {aReady, aRspValid, aBusy, aSck, aCs, aSdo});
      end
    end
  endtask

  task automatic test_write();
    int t, rdyCyc; bit ok; int p0;
    aRespWord = 16'h1234; p0 = aPulseCnt;
    issueA(1'b1, ADDR_OPERAND_A, 16'h0030, t, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL wr_accept got=timeout exp=ready"); end
    waitPulseA(p0, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL wr_pulse got=timeout exp=pulse"); end
    checks++;
    if ({aBusy, aReady, aCs} !== 3'b101) begin failures++; $display("[TB] FAIL wr_gap_pins got=%b exp=101", {aBusy, aReady, aCs}); end
    checks++; if (aCsFallCyc !== t + 1) begin failures++; $display("[TB] FAIL wr_cs_fall got=%0d exp=%0d", aCsFallCyc, t + 1); end
    checks++; if (aFirstRiseCyc !== t + 3) begin failures++; $display("[TB] FAIL wr_first_rise got=%0d exp=%0d", aFirstRiseCyc, t + 3); end
    checks++; if (aRiseCnt !== 24) begin failures++; $display("[TB] FAIL wr_rise_count got=%0d exp=24", aRiseCnt); end
    checks++; if (aSdoBits !== 24'h800030) begin failures++; $display("[TB] FAIL wr_sdo_stream got=%h exp=800030", aSdoBits); end
    checks++; if (aCsLowCnt !== 100) begin failures++; $display("[TB] FAIL wr_cs_low got=%0d exp=100", aCsLowCnt); end
    checks++; if (aPulseCyc !== t + 101) begin failures++; $display("[TB] FAIL wr_pulse_cyc got=%0d exp=%0d", aPulseCyc, t + 101); end
    checks++; if (aCsRiseCyc !== t + 101) begin failures++; $display("[TB] FAIL wr_cs_rise got=%0d exp=%0d", aCsRiseCyc, t + 101); end
    checks++; if (aRdataAtPulse !== 16'h1234) begin failures++; $display("[TB] FAIL wr_rdata got=%h exp=1234", aRdataAtPulse); end
    rdyCyc = -1;
    for (int i = 0; i < 20 && rdyCyc < 0; i++) begin
      waitCycles(1);
      if (aReady === 1'b1) rdyCyc = cyc;
    end
    checks++; if (rdyCyc !== t + 103) begin failures++; $display("[TB] FAIL wr_ready_return got=%0d exp=%0d", rdyCyc, t + 103); end
  endtask

  task automatic test_read();
    int t; bit ok; int p0;
    aRespWord = 16'h000C; p0 = aPulseCnt;
    issueA(1'b0, ADDR_GCD, 16'h5555, t, ok);
    waitPulseA(p0, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL rd_pulse got=timeout exp=pulse"); end
    checks++; if (aSdoBits !== 24'h025555) begin failures++; $display("[TB] FAIL rd_sdo_stream got=%h exp=025555", aSdoBits); end
    checks++; if (aRdataAtPulse !== 16'h000C) begin failures++; $display("[TB] FAIL rd_rdata got=%h exp=000c", aRdataAtPulse); end
    checks++; if (aPulseCyc !== t + 101) begin failures++; $display("[TB] FAIL rd_pulse_cyc got=%0d exp=%0d", aPulseCyc, t + 101); end
    waitCycles(30);
    checks++; if (aRdata !== 16'h000C) begin failures++; $display("[TB] FAIL rd_rdata_hold got=%h exp=000c", aRdata); end
    checks++; if ({aCs, aSck, aSdo, aRspValid} !== 4'b1000) begin failures++; $display("[TB] FAIL rd_idle_after got=%b exp=1000", {aCs, aSck, aSdo, aRspValid}); end
  endtask

  task automatic test_back_to_back();
    int t1, t2, rise1; bit ok, seen1; int p0; logic [23:0] bits1;
    aRespWord = 16'h0000; p0 = aPulseCnt; aReadyViol = 0;
    t2 = -1; rise1 = -1; seen1 = 0; bits1 = '0;
    issueA(1'b1, ADDR_OPERAND_A, 16'h1111, t1, ok);
    aValid = 1; aWrite = 1; aAddr = ADDR_OPERAND_B; aWdata = 16'h2222;
    for (int i = 0; i < 300 && t2 < 0; i++) begin
      if (!seen1 && aPulseCnt > p0) begin seen1 = 1; rise1 = aCsRiseCyc; bits1 = aSdoBits; end
      if (aReady === 1'b1) t2 = cyc;
      else waitCycles(1);
    end
    waitCycles(1);
    aValid = 0;
    checks++; if (t2 !== t1 + 103) begin failures++; $display("[TB] FAIL b2b_second_accept got=%0d exp=%0d", t2, t1 + 103); end
    waitPulseA(p0 + 1, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL b2b_pulse2 got=timeout exp=pulse"); end
    checks++; if (aCsFallCyc - rise1 !== 3) begin failures++; $display("[TB] FAIL b2b_cs_high got=%0d exp=3", aCsFallCyc - rise1); end
    checks++; if (bits1 !== 24'h801111) begin failures++; $display("[TB] FAIL b2b_frame1 got=%h exp=801111", bits1); end
    checks++; if (aSdoBits !== 24'h812222) begin failures++; $display("[TB] FAIL b2b_frame2 got=%h exp=812222", aSdoBits); end
    waitCycles(150);
    checks++; if (aReadyViol !== 0) begin failures++; $display("[TB] FAIL b2b_ready_in_frame got=%0d exp=0", aReadyViol); end
    checks++; if (aPulseCnt - p0 !== 2) begin failures++; $display("[TB] FAIL b2b_pulse_count got=%0d exp=2", aPulseCnt - p0); end
  endtask

  task automatic test_reset_mid();
    int t; bit ok, hit; int p0;
    aRespWord = 16'hBEEF; p0 = aPulseCnt; hit = 0;
    issueA(1'b0, ADDR_GCD, 16'h0000, t, ok);
    for (int i = 0; i < 200 && !hit; i++) begin
      if (aRiseCnt >= 10) hit = 1;
      else waitCycles(1);
    end
    checks++; if (!hit) begin failures++; $display("[TB] FAIL mid_rise10 got=timeout exp=10 rises"); end
    reset = 1;
    #1;
    checks++;
    if ({aCs, aSck, aSdo, aReady, aBusy} !== 5'b10010) begin
      failures++; $display("[TB] FAIL mid_reset_pins got=%b exp=10010", {aCs, aSck, aSdo, aReady, aBusy});
    end
    waitCycles(3);
    reset = 0;
    waitCycles(150);
    checks++; if (aPulseCnt !== p0) begin failures++; $display("[TB] FAIL mid_no_pulse got=%0d exp=%0d", aPulseCnt, p0); end
    checks++; if (aRdata !== 16'h0000) begin failures++; $display("[TB] FAIL mid_rdata_cleared got=%h exp=0000", aRdata); end
    aRespWord = 16'h0007;
    issueA(1'b0, ADDR_GCD, 16'h0000, t, ok);
    waitPulseA(p0, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL mid_next_pulse got=timeout exp=pulse"); end
    checks++; if (aRdataAtPulse !== 16'h0007) begin failures++; $display("[TB] FAIL mid_next_rdata got=%h exp=0007", aRdataAtPulse); end
    checks++; if (aPulseCyc !== t + 101) begin failures++; $display("[TB] FAIL mid_next_cyc got=%0d exp=%0d", aPulseCyc, t + 101); end
    checks++; if (aSdoBits !== 24'h020000) begin failures++; $display("[TB] FAIL mid_next_sdo got=%h exp=020000", aSdoBits); end
  endtask

  task automatic test_clkdiv5();
    int t; bit ok; int p0;
    bRespWord = 16'h00A5; p0 = bPulseCnt;
    issueB(1'b0, ADDR_PX_SOBEL, 16'h3C3C, t, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL d5_accept got=timeout exp=ready"); end
    waitPulseB(p0, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL d5_pulse got=timeout exp=pulse"); end
    checks++; if (bCsFallCyc !== t + 1) begin failures++; $display("[TB] FAIL d5_cs_fall got=%0d exp=%0d", bCsFallCyc, t + 1); end
    checks++; if (bFirstRiseCyc !== t + 6) begin failures++; $display("[TB] FAIL d5_first_rise got=%0d exp=%0d", bFirstRiseCyc, t + 6); end
    checks++; if (bFirstFallCyc !== t + 11) begin failures++; $display("[TB] FAIL d5_first_fall got=%0d exp=%0d", bFirstFallCyc, t + 11); end
    checks++; if (bSecondRiseCyc !== t + 16) begin failures++; $display("[TB] FAIL d5_second_rise got=%0d exp=%0d", bSecondRiseCyc, t + 16); end
    checks++; if (bRiseCnt !== 24) begin failures++; $display("[TB] FAIL d5_rise_count got=%0d exp=24", bRiseCnt); end
    checks++; if (bSdoBits !== 24'h043C3C) begin failures++; $display("[TB] FAIL d5_sdo_stream got=%h exp=043c3c", bSdoBits); end
    checks++; if (bCsLowCnt !== 250) begin failures++; $display("[TB] FAIL d5_cs_low got=%0d exp=250", bCsLowCnt); end
    checks++; if (bPulseCyc !== t + 251) begin failures++; $display("[TB] FAIL d5_pulse_cyc got=%0d exp=%0d", bPulseCyc, t + 251); end
    checks++; if (bRdataAtPulse !== 16'h00A5) begin failures++; $display("[TB] FAIL d5_rdata got=%h exp=00a5", bRdataAtPulse); end
  endtask

  initial begin
    #1;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_reset_mid();
    test_clkdiv5();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/sobel_gcd_spi_host.md
# sobel_gcd_spi_host

SPI initiator that drives the serial port of the sobel/gcd accelerator from a parallel request/response interface. It serialises one command byte plus one data word per transaction and captures the responder's returned word. It sits in the test harness and host-side FPGA wrapper, facing the accelerator's `spi_sck/sdi/cs/sdo` pins. It is the counterpart of the accelerator's SPI responder.

## Interface
Parameters:
- `DATA_WIDTH`, 16: payload word width; must equal the accelerator's operand width.
- `CLK_DIV`, 2: SCK half-period in `clk_i` cycles; values below 2 are an elaboration error.

Ports:
- `clk_i` in 1: single clock.
- `reset_i` in 1: reset, asynchronous, active-high.
- `req_valid_i` in 1: request present.
- `req_ready_o` out 1: request accepted when high with `req_valid_i`.
- `req_write_i` in 1: 1 = write, 0 = read.
- `req_addr_i` in 7: responder register address.
- `req_wdata_i` in DATA_WIDTH: write payload; ignored on reads but still shifted out.
- `rsp_valid_o` out 1: one-cycle pulse at transaction end, for reads and writes.
- `rsp_rdata_o` out DATA_WIDTH: word captured on SDI during the data phase; held until the next pulse.
- `busy_o` out 1: high from accept until the end of the inter-frame gap.
- `spi_sck_o` out 1: SPI clock, mode 0, idle low.
- `spi_cs_o` out 1: chip select, active-low, idle high.
- `spi_sdo_o` out 1: host-to-responder data, MSB first.
- `spi_sdi_i` in 1: responder-to-host data.

## Operation
- Frame is N = 8 + DATA_WIDTH bits, MSB first.
  - The command byte is `{req_write_i, req_addr_i}`, followed by the data word.
  - Request fields are latched on accept; later changes have no effect.
- FSM states and transitions:
  - IDLE: `req_ready_o`=1. Accept moves to SETUP.
  - SETUP: CS low, SDO = frame bit N-1. Lasts CLK_DIV cycles, then SHIFT.
  - SHIFT: SCK alternates CLK_DIV cycles high and CLK_DIV cycles low, starting high. At every falling edge SDO advances to the next bit. After N high phases, moves to HOLD.
  - HOLD: CS low, SCK low, lasts CLK_DIV cycles.
  - GAP: CS high, lasts CLK_DIV cycles, then IDLE.
- SDI sampling:
  - SDI is sampled in the last `clk_i` cycle of each SCK high phase.
  - Sampled bits shift into a capture register.
  - The low DATA_WIDTH bits of the capture register go to `rsp_rdata_o` on entry to GAP.
  - Command-phase bits are discarded.
- `req_ready_o` is low in every state except IDLE. `req_valid_i` while busy is ignored; no queueing.
- Reset values: `req_ready_o`=1, `rsp_valid_o`=0, `rsp_rdata_o`=0, `busy_o`=0, `spi_sck_o`=0, `spi_cs_o`=1, `spi_sdo_o`=0.
- Reset mid-frame: pins go to their idle values immediately (asynchronous). No `rsp_valid_o` is produced. The responder sees an aborted frame (CS rises).
- `spi_sdo_o` is 0 outside SETUP/SHIFT/HOLD.

## Timing
- Accept at cycle T. CS falls at T+1.
- First SCK rise at T+1+CLK_DIV. The rise for bit k (k=0 is the MSB) is at T+1+CLK_DIV+2·k·CLK_DIV.
- CS rises and `rsp_valid_o` pulses at T+1+2·CLK_DIV·(N+1). With defaults (N=24): T+101.
- `req_ready_o` returns high at T+1+2·CLK_DIV·(N+1)+CLK_DIV. The next accept can occur that same cycle.
- Minimum CS-high time between frames is CLK_DIV cycles.
- All outputs are registered; there are no combinational paths from inputs to pins.

## Structure
- Package `sobel_gcd_spi_pkg` holds:
  - `CMD_WIDTH`=8.
  - Register addresses: `ADDR_OPERAND_A`=0x00, `ADDR_OPERAND_B`=0x01, `ADDR_GCD`=0x02, `ADDR_PX_GRAY`=0x03, `ADDR_PX_SOBEL`=0x04. Pixel registers are zero-extended to DATA_WIDTH.
  - The FSM state enum.
- One sub-module, `spi_host_sck_gen`: half-period counter that produces `sck`, a `rise` strobe, a `fall` strobe and a `sample` strobe, enabled only in SHIFT.
- The top holds the FSM, bit counter, shift-out and capture registers.

## Test plan
- Reset held, then released with no request -> all pins at idle values, `req_ready_o`=1 and `rsp_valid_o`=0 for 200 cycles.
- Write `ADDR_OPERAND_A`, data 0x0030, defaults -> SDO stream 0x80 then 0x0030 across 24 SCK rises; CS low for exactly 100 cycles; `rsp_valid_o` pulse at T+101.
- Read `ADDR_GCD` against a bench responder returning 0x000C -> command byte 0x02 on SDO, `rsp_rdata_o`=0x000C at the pulse, held afterwards.
- `req_valid_i` held high for two writes -> second CS fall at least CLK_DIV cycles after the first CS rise; `req_ready_o` low throughout each frame; exactly two pulses.
- `reset_i` asserted after the 10th SCK rise -> CS=1, SCK=0, SDO=0 in the same cycle; no pulse; next read after release completes correctly.
- CLK_DIV=5, read `ADDR_PX_SOBEL` returning 0x00A5 -> SCK half-period of 5 cycles, pulse at T+251, `rsp_rdata_o`=0x00A5.
